// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the 1024x768 mode, used by the sync generator
// and the console peripheral.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE   = 1024;
  localparam int unsigned V_VISIBLE   = 768;

  localparam int unsigned DEF_H_FP    = 24;
  localparam int unsigned DEF_H_SYNC  = 136;
  localparam int unsigned DEF_H_BP    = 160;
  localparam int unsigned DEF_V_FP    = 3;
  localparam int unsigned DEF_V_SYNC  = 6;
  localparam int unsigned DEF_V_BP    = 29;

  localparam int unsigned X_RADIX     = 32;
  localparam int unsigned Y_RADIX     = 48;
  localparam int unsigned X_LO_W      = 5;
  localparam int unsigned X_HI_W      = 6;
  localparam int unsigned Y_LO_W      = 6;
  localparam int unsigned Y_HI_W      = 5;

  localparam int unsigned H_TOTAL_MAX = 2048;
  localparam int unsigned V_TOTAL_MAX = 1536;

  // Compares a split {hi,lo} position against a split threshold field by field.
  function automatic logic split_ge(input logic [7:0] hi, input logic [7:0] lo,
                                    input logic [7:0] thr_hi, input logic [7:0] thr_lo);
    return (hi > thr_hi) || ((hi == thr_hi) && (lo >= thr_lo));
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: sync strobes, blanking and the split pixel position.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic              hsync;
  logic              vsync;
  logic              blank;
  logic [X_LO_W-1:0] x_lo;
  logic [X_HI_W-1:0] x_hi;
  logic [Y_LO_W-1:0] y_lo;
  logic [Y_HI_W-1:0] y_hi;
  logic              frame_start;

  modport master (output hsync, vsync, blank, x_lo, x_hi, y_lo, y_hi, frame_start);
  modport slave  (input  hsync, vsync, blank, x_lo, x_hi, y_lo, y_hi, frame_start);

endinterface

// File: rtl/split_counter.sv
// Two-field counter: lo counts modulo LO_RADIX and carries into hi; the pair
// wraps to zero after reaching {TERM_HI,TERM_LO}. Next-state is exported.
module split_counter #(
  parameter int unsigned LO_W     = 5,
  parameter int unsigned HI_W     = 6,
  parameter int unsigned LO_RADIX = 32,
  parameter int unsigned TERM_HI  = 41,
  parameter int unsigned TERM_LO  = 31
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [LO_W-1:0] lo,
  output logic [HI_W-1:0] hi,
  output logic [LO_W-1:0] lo_nxt,
  output logic [HI_W-1:0] hi_nxt,
  output logic            wrap
);

  localparam logic [LO_W-1:0] LO_MAX_C  = LO_W'(LO_RADIX - 1);
  localparam logic [LO_W-1:0] TERM_LO_C = LO_W'(TERM_LO);
  localparam logic [HI_W-1:0] TERM_HI_C = HI_W'(TERM_HI);

  logic [LO_W-1:0] lo_r;
  logic [HI_W-1:0] hi_r;
  logic [LO_W-1:0] lo_nxt_s;
  logic [HI_W-1:0] hi_nxt_s;
  logic            at_term_s;

  assign at_term_s = (lo_r == TERM_LO_C) && (hi_r == TERM_HI_C);

  // Next position: hold, terminal wrap, lo-field carry, or plain increment.
  always_comb begin
    lo_nxt_s = lo_r;
    hi_nxt_s = hi_r;
    if (!inc) begin
      lo_nxt_s = lo_r;
      hi_nxt_s = hi_r;
    end else if (at_term_s) begin
      lo_nxt_s = {LO_W{1'b0}};
      hi_nxt_s = {HI_W{1'b0}};
    end else if (lo_r == LO_MAX_C) begin
      lo_nxt_s = {LO_W{1'b0}};
      hi_nxt_s = hi_r + 1'b1;
    end else begin
      lo_nxt_s = lo_r + 1'b1;
      hi_nxt_s = hi_r;
    end
  end

  // Position register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_r <= {LO_W{1'b0}};
      hi_r <= {HI_W{1'b0}};
    end else begin
      lo_r <= lo_nxt_s;
      hi_r <= hi_nxt_s;
    end
  end

  assign lo     = lo_r;
  assign hi     = hi_r;
  assign lo_nxt = lo_nxt_s;
  assign hi_nxt = hi_nxt_s;
  assign wrap   = inc && at_term_s;

endmodule

// File: rtl/vga_sync_gen.sv
// 1024x768 VGA timing generator. Strobes are decoded from the counters' next
// state and registered, so they line up with the position in the same cycle.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_ON   = H_VISIBLE + H_FP;
  localparam int unsigned HS_OFF  = HS_ON + H_SYNC;
  localparam int unsigned VS_ON   = V_VISIBLE + V_FP;
  localparam int unsigned VS_OFF  = VS_ON + V_SYNC;

  localparam logic [7:0] HS_ON_HI  = 8'(HS_ON / X_RADIX);
  localparam logic [7:0] HS_ON_LO  = 8'(HS_ON % X_RADIX);
  localparam logic [7:0] HS_OFF_HI = 8'(HS_OFF / X_RADIX);
  localparam logic [7:0] HS_OFF_LO = 8'(HS_OFF % X_RADIX);
  localparam logic [7:0] VS_ON_HI  = 8'(VS_ON / Y_RADIX);
  localparam logic [7:0] VS_ON_LO  = 8'(VS_ON % Y_RADIX);
  localparam logic [7:0] VS_OFF_HI = 8'(VS_OFF / Y_RADIX);
  localparam logic [7:0] VS_OFF_LO = 8'(VS_OFF % Y_RADIX);
  localparam logic [7:0] BL_X_HI   = 8'(H_VISIBLE / X_RADIX);
  localparam logic [7:0] BL_X_LO   = 8'(H_VISIBLE % X_RADIX);
  localparam logic [7:0] BL_Y_HI   = 8'(V_VISIBLE / Y_RADIX);
  localparam logic [7:0] BL_Y_LO   = 8'(V_VISIBLE % Y_RADIX);

  // The split fields cannot represent positions beyond these totals.
  if (H_TOTAL > H_TOTAL_MAX) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL exceeds the 11-bit split x range");
  end
  if (V_TOTAL > V_TOTAL_MAX) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL exceeds the 48x32 split y range");
  end

  logic [X_LO_W-1:0] x_lo_r;
  logic [X_HI_W-1:0] x_hi_r;
  logic [Y_LO_W-1:0] y_lo_r;
  logic [Y_HI_W-1:0] y_hi_r;
  logic [X_LO_W-1:0] x_lo_nxt_s;
  logic [X_HI_W-1:0] x_hi_nxt_s;
  logic [Y_LO_W-1:0] y_lo_nxt_s;
  logic [Y_HI_W-1:0] y_hi_nxt_s;
  logic              x_wrap_s;
  logic              y_wrap_s;

  split_counter #(
    .LO_W(X_LO_W), .HI_W(X_HI_W), .LO_RADIX(X_RADIX),
    .TERM_HI((H_TOTAL - 1) / X_RADIX), .TERM_LO((H_TOTAL - 1) % X_RADIX)
  ) u_x_cnt (
    .clk(clk), .rst_n(rst_n), .inc(1'b1),
    .lo(x_lo_r), .hi(x_hi_r), .lo_nxt(x_lo_nxt_s), .hi_nxt(x_hi_nxt_s),
    .wrap(x_wrap_s)
  );

  split_counter #(
    .LO_W(Y_LO_W), .HI_W(Y_HI_W), .LO_RADIX(Y_RADIX),
    .TERM_HI((V_TOTAL - 1) / Y_RADIX), .TERM_LO((V_TOTAL - 1) % Y_RADIX)
  ) u_y_cnt (
    .clk(clk), .rst_n(rst_n), .inc(x_wrap_s),
    .lo(y_lo_r), .hi(y_hi_r), .lo_nxt(y_lo_nxt_s), .hi_nxt(y_hi_nxt_s),
    .wrap(y_wrap_s)
  );

  logic [7:0] xh_s, xl_s, yh_s, yl_s;
  logic       hsync_d_s, vsync_d_s, blank_d_s;
  logic       hsync_r, vsync_r, blank_r, frame_start_r;

  assign xh_s = {2'b00, x_hi_nxt_s};
  assign xl_s = {3'b000, x_lo_nxt_s};
  assign yh_s = {3'b000, y_hi_nxt_s};
  assign yl_s = {2'b00, y_lo_nxt_s};

  // Window decode of the position the counters will hold after this edge.
  always_comb begin
    hsync_d_s = ~(split_ge(xh_s, xl_s, HS_ON_HI, HS_ON_LO) &&
                  !split_ge(xh_s, xl_s, HS_OFF_HI, HS_OFF_LO));
    vsync_d_s = ~(split_ge(yh_s, yl_s, VS_ON_HI, VS_ON_LO) &&
                  !split_ge(yh_s, yl_s, VS_OFF_HI, VS_OFF_LO));
    blank_d_s = split_ge(xh_s, xl_s, BL_X_HI, BL_X_LO) ||
                split_ge(yh_s, yl_s, BL_Y_HI, BL_Y_LO);
  end

  // Registered strobes; reset values equal the decode of position (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      blank_r       <= 1'b0;
      frame_start_r <= 1'b1;
    end else begin
      hsync_r       <= hsync_d_s;
      vsync_r       <= vsync_d_s;
      blank_r       <= blank_d_s;
      frame_start_r <= y_wrap_s;
    end
  end

  assign vga.hsync       = hsync_r;
  assign vga.vsync       = vsync_r;
  assign vga.blank       = blank_r;
  assign vga.frame_start = frame_start_r;
  assign vga.x_lo        = x_lo_r;
  assign vga.x_hi        = x_hi_r;
  assign vga.y_lo        = y_lo_r;
  assign vga.y_hi        = y_hi_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default and alternate timing instances checked every
// cycle against an arithmetic timing model, plus a table of hand-derived points.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_sync_gen_if vga_def();
  vga_sync_gen_if vga_alt();

  vga_sync_gen u_def (.clk(clk), .rst_n(rst_n), .vga(vga_def));
  vga_sync_gen #(
    .H_FP(16), .H_SYNC(96), .H_BP(48), .V_FP(10), .V_SYNC(2), .V_BP(33)
  ) u_alt (.clk(clk), .rst_n(rst_n), .vga(vga_alt));

  // {hsync, vsync, blank, frame_start, x_hi, x_lo, y_hi, y_lo}
  logic [25:0] def_vec, alt_vec;
  assign def_vec = {vga_def.hsync, vga_def.vsync, vga_def.blank, vga_def.frame_start,
                    vga_def.x_hi, vga_def.x_lo, vga_def.y_hi, vga_def.y_lo};
  assign alt_vec = {vga_alt.hsync, vga_alt.vsync, vga_alt.blank, vga_alt.frame_start,
                    vga_alt.x_hi, vga_alt.x_lo, vga_alt.y_hi, vga_alt.y_lo};

  typedef struct {
    int unsigned t;
    logic        alt;
    logic [25:0] exp;
    string       name;
  } vec_t;

  localparam int unsigned CYC_CAP = 95000;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned t;
  int unsigned cyc;
  vec_t        tbl[$];

  function automatic logic [25:0] pack(input logic hs, input logic vs, input logic bl,
                                       input logic fs, input int unsigned xh,
                                       input int unsigned xl, input int unsigned yh,
                                       input int unsigned yl);
    return {hs, vs, bl, fs, 6'(xh), 5'(xl), 5'(yh), 6'(yl)};
  endfunction

  // Expected outputs t cycles after the last reset, from the raster rules alone.
  function automatic logic [25:0] model(input int unsigned tt, input int unsigned hfp,
                                        input int unsigned hsw, input int unsigned hbp,
                                        input int unsigned vfp, input int unsigned vsw,
                                        input int unsigned vbp);
    int unsigned ht, vt, x, y;
    logic hs, vs, bl, fs;
    ht = 1024 + hfp + hsw + hbp;
    vt = 768 + vfp + vsw + vbp;
    x  = tt % ht;
    y  = (tt / ht) % vt;
    hs = !((x >= 1024 + hfp) && (x < 1024 + hfp + hsw));
    vs = !((y >= 768 + vfp) && (y < 768 + vfp + vsw));
    bl = (x >= 1024) || (y >= 768);
    fs = (x == 0) && (y == 0);
    return pack(hs, vs, bl, fs, x / 32, x % 32, y / 48, y % 48);
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d: got %h expected %h (hs,vs,bl,fs,xh,xl,yh,yl)",
               name, t, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // One clock: advance the model position, then compare both instances.
  task automatic step();
    @(posedge clk);
    if (rst_n) t++;
    else t = 0;
    cyc++;
    @(negedge clk);
    if (cyc > CYC_CAP) begin
      miscompares++;
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, CYC_CAP);
      finish_run();
    end
    check("model_def", def_vec, model(t, 24, 136, 160, 3, 6, 29));
    check("model_alt", alt_vec, model(t, 16, 96, 48, 10, 2, 33));
  endtask

  task automatic add(input int unsigned tt, input logic alt, input string name,
                     input logic [25:0] exp);
    vec_t v;
    v.t = tt; v.alt = alt; v.name = name; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    vectors = 0; miscompares = 0; t = 0; cyc = 0;

    add(1,     1'b0, "first_after_reset", pack(1, 1, 0, 0, 0,  1,  0, 0));
    add(31,    1'b0, "x31",               pack(1, 1, 0, 0, 0,  31, 0, 0));
    add(32,    1'b0, "x_lo_carry",        pack(1, 1, 0, 0, 1,  0,  0, 0));
    add(1023,  1'b0, "last_visible_x",    pack(1, 1, 0, 0, 31, 31, 0, 0));
    add(1024,  1'b0, "blank_start",       pack(1, 1, 1, 0, 32, 0,  0, 0));
    add(1039,  1'b1, "alt_before_hsync",  pack(1, 1, 1, 0, 32, 15, 0, 0));
    add(1040,  1'b1, "alt_hsync_fall",    pack(0, 1, 1, 0, 32, 16, 0, 0));
    add(1047,  1'b0, "before_hsync",      pack(1, 1, 1, 0, 32, 23, 0, 0));
    add(1048,  1'b0, "hsync_fall",        pack(0, 1, 1, 0, 32, 24, 0, 0));
    add(1135,  1'b1, "alt_hsync_last",    pack(0, 1, 1, 0, 35, 15, 0, 0));
    add(1136,  1'b1, "alt_hsync_rise",    pack(1, 1, 1, 0, 35, 16, 0, 0));
    add(1183,  1'b0, "hsync_last",        pack(0, 1, 1, 0, 36, 31, 0, 0));
    add(1183,  1'b1, "alt_line_end",      pack(1, 1, 1, 0, 36, 31, 0, 0));
    add(1184,  1'b0, "hsync_rise",        pack(1, 1, 1, 0, 37, 0,  0, 0));
    add(1184,  1'b1, "alt_line1_start",   pack(1, 1, 0, 0, 0,  0,  0, 1));
    add(1343,  1'b0, "line_end",          pack(1, 1, 1, 0, 41, 31, 0, 0));
    add(1344,  1'b0, "line1_start",       pack(1, 1, 0, 0, 0,  0,  0, 1));
    add(2392,  1'b0, "hsync_fall_line1",  pack(0, 1, 1, 0, 32, 24, 0, 1));
    add(64511, 1'b0, "line47_end",        pack(1, 1, 1, 0, 41, 31, 0, 47));
    add(64512, 1'b0, "y_lo_carry",        pack(1, 1, 0, 0, 0,  0,  1, 0));

    rst_n = 1'b0;
    step();
    step();
    check("reset_state_def", def_vec, pack(1, 1, 0, 1, 0, 0, 0, 0));
    check("reset_state_alt", alt_vec, pack(1, 1, 0, 1, 0, 0, 0, 0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      while (t < tbl[i].t) step();
      check(tbl[i].name, tbl[i].alt ? alt_vec : def_vec, tbl[i].exp);
    end

    // Reset while inside the hsync pulse, then release.
    while ((t % 1344) != 1100) step();
    check("pre_reset_in_hsync", def_vec, pack(0, 1, 1, 0, 34, 12, 1, 0));
    rst_n = 1'b0;
    step();
    check("midline_reset_def", def_vec, pack(1, 1, 0, 1, 0, 0, 0, 0));
    check("midline_reset_alt", alt_vec, pack(1, 1, 0, 1, 0, 0, 0, 0));
    rst_n = 1'b1;
    step();
    check("release_x1", def_vec, pack(1, 1, 0, 0, 0, 1, 0, 0));

    // Random run lengths and reset pulse widths.
    for (int k = 0; k < 6; k++) begin
      int unsigned run_len;
      int unsigned rst_len;
      run_len = $urandom_range(2000, 1);
      rst_len = $urandom_range(3, 1);
      repeat (run_len) step();
      rst_n = 1'b0;
      repeat (rst_len) step();
      rst_n = 1'b1;
    end

    repeat (2 * 1344 + 8) step();
    finish_run();
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_FP, 24, horizontal front porch in pixels.
REQ-002 Parameter H_SYNC, 136, horizontal sync width in pixels.
REQ-003 Parameter H_BP, 160, horizontal back porch in pixels.
REQ-004 Parameter V_FP, 3, vertical front porch in lines.
REQ-005 Parameter V_SYNC, 6, vertical sync width in lines.
REQ-006 Parameter V_BP, 29, vertical back porch in lines.
REQ-007 clk  input  1  pixel clock (64 MHz).
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 hsync  output  1  horizontal sync, active-low.
REQ-010 vsync  output  1  vertical sync, active-low.
REQ-011 blank  output  1  high outside the 1024x768 visible area.
REQ-012 x_lo  output  5  pixel x mod 32.
REQ-013 x_hi  output  6  pixel x div 32.
REQ-014 y_lo  output  6  line y mod 48.
REQ-015 y_hi  output  5  line y div 48.
REQ-016 frame_start  output  1  one-cycle pulse while (x,y)=(0,0).

Function
REQ-017 Visible area SHALL be fixed at 1024x768.
REQ-018 H_TOTAL SHALL be 1024+H_FP+H_SYNC+H_BP. With defaults it is 1344, so x_hi spans 0..41.
REQ-019 V_TOTAL SHALL be 768+V_FP+V_SYNC+V_BP. With defaults it is 806, so y_hi spans 0..16.
REQ-020 Position counting:
- x SHALL be held as {x_hi,x_lo}.
- x_lo SHALL increment every cycle and wrap 31->0 with a carry into x_hi.
- No multiplier or full-width x comparator SHALL be used.
REQ-021 End of line: when x=H_TOTAL-1, x_lo and x_hi SHALL both go to 0 on the next cycle, and y SHALL advance by one line.
REQ-022 Line counting:
- y_lo SHALL increment once per line and wrap 47->0 with a carry into y_hi.
- y_lo and y_hi SHALL change only on the cycle in which x wraps.
REQ-023 End of frame: when x=H_TOTAL-1 and y=V_TOTAL-1, both x and y SHALL wrap to 0.
- Default frame wrap point: y_hi=16, y_lo=37.
REQ-024 Output registration:
- hsync, vsync, blank and frame_start SHALL be registered.
- In every cycle they SHALL correspond to the x/y values presented in that same cycle, with zero skew.
REQ-025 blank SHALL be 1 iff x>=1024 or y>=768, i.e. x_hi>=32 or (y_hi=16).
REQ-026 hsync SHALL be 0 iff 1024+H_FP <= x < 1024+H_FP+H_SYNC. With defaults this is x in 1048..1183.
REQ-027 vsync SHALL be 0 iff 768+V_FP <= y < 768+V_FP+V_SYNC, for all x in those lines. With defaults this is y_hi=16 and y_lo in 3..8.
REQ-028 frame_start SHALL be high for exactly one cycle per frame.
REQ-029 The timing pattern SHALL be strictly periodic with period H_TOTAL*V_TOTAL cycles (1,083,264 with defaults).
REQ-030 Parameter legality: parameters that give H_TOTAL>2048 or V_TOTAL>1536 SHALL be rejected at elaboration.

Reset
REQ-031 While rst_n=0 at a clk edge, the following SHALL be set next cycle:
- x_lo, x_hi, y_lo, y_hi = 0
- hsync = 1, vsync = 1
- blank = 0
- frame_start = 1
REQ-032 Reset asserted mid-line or mid-frame SHALL restart timing at (0,0) with no partial sync pulse afterwards.
REQ-033 The first cycle after reset release SHALL be x=1, with frame_start=0.

Structure
REQ-034 The 1024/768 visible constants, the default porch/sync values and the 32/48 split radices SHALL live in shared package vga_timing_pkg, used by this block and by the console peripheral.
REQ-035 One sub-module, split_counter, SHALL implement a two-field (lo radix, hi field) counter with increment-enable and terminal-value wrap. It SHALL be instantiated twice: once for x, once for y.
REQ-036 The block SHALL contain no memories and no combinational output paths.

Verification
REQ-037 Release reset; observe hsync -> low at x=1048 (x_hi=32, x_lo=24) and high again at x=1184; period 1344 cycles.
REQ-038 Run one full frame -> vsync low for exactly 6*1344=8064 cycles starting at y=771; frame_start pulses 1,083,264 cycles apart.
REQ-039 At x=1343, y=767 -> next cycle x=0, y_hi=16, y_lo=0, blank=1; at x=1023, y=0 -> blank 0, then next cycle blank=1.
REQ-040 At y=47 line end -> y_lo 0, y_hi 1; at x=31 -> x_lo 0, x_hi 1; the decode {hi*32+lo} and {hi*48+lo} is monotonic across a frame (checked by scoreboard).
REQ-041 Assert rst_n=0 for 1 cycle at x=1100, y=773 (in hsync and vsync) -> next cycle all counters 0, hsync=1, vsync=1, frame_start=1.
REQ-042 Non-default parameters H_FP=16, H_SYNC=96, H_BP=48, V_FP=10, V_SYNC=2, V_BP=33 -> H_TOTAL=1184, V_TOTAL=813; sync windows match REQ-026/027.
